// File: rtl/exh_sweep_if.sv
// Handshake and vector/result bundle between the exhaustive sweep driver and its cone/consumer.
// The sig signal exists only when EXH_SWEEP_SIGNATURE_EN is defined.
interface exh_sweep_if #(
    parameter int unsigned N_IN = 18
);
    logic              start;
    logic              abort;
    logic              res_ack;
    logic              y;
    logic [N_IN-1:0]   x;
    logic              busy;
    logic              done;
    logic [N_IN:0]     onset_cnt;
    logic [N_IN-1:0]   first_idx;
    logic              first_vld;
`ifdef EXH_SWEEP_SIGNATURE_EN
    logic [15:0]       sig;

    modport master (
        input  start, abort, res_ack, y,
        output x, busy, done, onset_cnt, first_idx, first_vld, sig
    );

    modport slave (
        output start, abort, res_ack, y,
        input  x, busy, done, onset_cnt, first_idx, first_vld, sig
    );
`else
    modport master (
        input  start, abort, res_ack, y,
        output x, busy, done, onset_cnt, first_idx, first_vld
    );

    modport slave (
        output start, abort, res_ack, y,
        input  x, busy, done, onset_cnt, first_idx, first_vld
    );
`endif
endinterface

// File: rtl/exh_sweep_driver.sv
// Exhaustive input sweep of a single-output cone: counts onset minterms and the lowest onset index.
// Optional MISR signature over the sampled output stream under EXH_SWEEP_SIGNATURE_EN.
module exh_sweep_driver #(
    parameter int unsigned N_IN          = 18,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    exh_sweep_if.master  bus
);
    localparam int unsigned CNT_W = N_IN + 1;
    localparam int unsigned H_W   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [H_W-1:0]    hold;
    logic [N_IN-1:0]   x;
    logic [CNT_W-1:0]  onset_cnt;
    logic [N_IN-1:0]   first_idx;
    logic              first_vld;
    logic              busy;
    logic              done;

    logic              sample_c;
    logic              last_vec_c;

    assign sample_c   = (hold == H_W'(SETTLE_CYCLES));
    assign last_vec_c = &x;

`ifdef EXH_SWEEP_SIGNATURE_EN
    logic [15:0] sig;

    // CRC-16/CCITT style MISR step, x^16+x^12+x^5+1
    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ ({16{s[15] ^ b}} & 16'h1021);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 16'hFFFF;
        end else if (state == IDLE && bus.start) begin
            sig <= 16'hFFFF;
        end else if (state == RUN && !bus.abort && sample_c) begin
            sig <= misr_next(sig, bus.y);
        end
    end

    assign bus.sig = sig;
`endif

    // Sweep FSM: every vector is held SETTLE_CYCLES+1 cycles and y sampled on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            x         <= '0;
            onset_cnt <= '0;
            first_idx <= '0;
            first_vld <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        hold      <= '0;
                        x         <= '0;
                        onset_cnt <= '0;
                        first_idx <= '0;
                        first_vld <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        // Partial results stay readable but are never flagged done
                        state <= IDLE;
                        hold  <= '0;
                        x     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (!sample_c) begin
                        hold <= hold + H_W'(1);
                    end else begin
                        if (bus.y) begin
                            onset_cnt <= onset_cnt + CNT_W'(1);
                            if (!first_vld) begin
                                first_idx <= x;
                                first_vld <= 1'b1;
                            end
                        end
                        hold <= '0;
                        x    <= x + N_IN'(1);
                        if (last_vec_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (bus.res_ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x         = x;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.onset_cnt = onset_cnt;
    assign bus.first_idx = first_idx;
    assign bus.first_vld = first_vld;

endmodule

// File: tb/tb_exh_sweep_driver.sv
// Directed bench for exh_sweep_driver: three instances (N=4/S=1, N=4/S=0, N=10/S=0 with a cone model).
module tb_exh_sweep_driver;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exh_sweep_if #(.N_IN(4))  if_s1 ();
    exh_sweep_if #(.N_IN(4))  if_s0 ();
    exh_sweep_if #(.N_IN(10)) if_n10 ();

    exh_sweep_driver #(.N_IN(4),  .SETTLE_CYCLES(1)) u_s1  (.clk(clk), .rst_n(rst_n), .bus(if_s1));
    exh_sweep_driver #(.N_IN(4),  .SETTLE_CYCLES(0)) u_s0  (.clk(clk), .rst_n(rst_n), .bus(if_s0));
    exh_sweep_driver #(.N_IN(10), .SETTLE_CYCLES(0)) u_n10 (.clk(clk), .rst_n(rst_n), .bus(if_n10));

    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    logic y_reg;

    function automatic logic cone10(input logic [9:0] v);
        return (v[0] ^ v[3]) & (v[9] | v[5]) & ~v[7];
    endfunction

    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic b);
        logic fb;
        fb = s[15] ^ b;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge clk) y_reg <= if_s1.x[3] & if_s1.x[0];

    always_comb begin
        case (mode)
            0:       if_s1.y = 1'b0;
            1:       if_s1.y = 1'b1;
            default: if_s1.y = y_reg;
        endcase
    end
    assign if_s0.y  = 1'b1;
    assign if_n10.y = cone10(if_n10.x);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return if_s0.done;
            1:       return if_s1.done;
            default: return if_n10.done;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       if_s0.start = v;
            1:       if_s1.start = v;
            default: if_n10.start = v;
        endcase
    endtask

    task automatic set_ack(input int which, input logic v);
        case (which)
            0:       if_s0.res_ack = v;
            1:       if_s1.res_ack = v;
            default: if_n10.res_ack = v;
        endcase
    endtask

    // Pulse start and count edges from the start edge until done rises (bounded)
    task automatic sweep(input int which, input bit chk_order, input int budget, output int edges);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        edges = 0;
        while (!done_of(which) && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (chk_order && !if_s1.done)
                check($sformatf("order_e%0d", edges), 32'(if_s1.x), 32'(edges / 2));
        end
    endtask

    task automatic ack(input int which);
        set_ack(which, 1'b1);
        @(posedge clk);
        #1;
        set_ack(which, 1'b0);
        check($sformatf("ack_done_%0d", which), 32'(done_of(which)), 32'd0);
    endtask

    initial begin
        int          edges;
        int          n;
        int          gold_cnt;
        int          gold_first;
        bit          seen_done;
        logic [15:0] sig_exp;

        rst_n = 1'b0;
        if_s1.start = 1'b0;  if_s1.abort = 1'b0;  if_s1.res_ack = 1'b0;
        if_s0.start = 1'b0;  if_s0.abort = 1'b0;  if_s0.res_ack = 1'b0;
        if_n10.start = 1'b0; if_n10.abort = 1'b0; if_n10.res_ack = 1'b0;
        #2;
        check("rst_x",    32'(if_s1.x), 32'd0);
        check("rst_busy", 32'(if_s1.busy), 32'd0);
        check("rst_done", 32'(if_s1.done), 32'd0);
        check("rst_cnt",  32'(if_s1.onset_cnt), 32'd0);
        check("rst_vld",  32'(if_s1.first_vld), 32'd0);
`ifdef EXH_SWEEP_SIGNATURE_EN
        check("rst_sig",  32'(if_s1.sig), 32'hFFFF);
`endif
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // y tied 0, settle 1
        mode = 0;
        sweep(1, 1'b0, 200, edges);
        check("t1_latency", 32'(edges), 32'd32);
        check("t1_cnt",  32'(if_s1.onset_cnt), 32'd0);
        check("t1_vld",  32'(if_s1.first_vld), 32'd0);
        check("t1_x",    32'(if_s1.x), 32'd0);
        check("t1_busy", 32'(if_s1.busy), 32'd0);
`ifdef EXH_SWEEP_SIGNATURE_EN
        sig_exp = 16'hFFFF;
        for (int i = 0; i < 16; i++) sig_exp = misr_model(sig_exp, 1'b0);
        check("t1_sig", 32'(if_s1.sig), 32'(sig_exp));
`else
        sig_exp = 16'h0000;
`endif
        // start while DONE is ignored, ack returns to IDLE
        if_s1.start = 1'b1;
        @(posedge clk);
        #1;
        if_s1.start = 1'b0;
        check("done_start_ign_done", 32'(if_s1.done), 32'd1);
        check("done_start_ign_busy", 32'(if_s1.busy), 32'd0);
        ack(1);
        check("ack_busy", 32'(if_s1.busy), 32'd0);

        // y tied 1, settle 0
        sweep(0, 1'b0, 200, edges);
        check("t2_latency", 32'(edges), 32'd16);
        check("t2_cnt",   32'(if_s0.onset_cnt), 32'd16);
        check("t2_first", 32'(if_s0.first_idx), 32'd0);
        check("t2_vld",   32'(if_s0.first_vld), 32'd1);
        ack(0);

        // y = x[3]&x[0] through a register, hold order checked
        mode = 2;
        sweep(1, 1'b1, 200, edges);
        check("t3_latency", 32'(edges), 32'd32);
        check("t3_cnt",   32'(if_s1.onset_cnt), 32'd4);
        check("t3_first", 32'(if_s1.first_idx), 32'd9);
        check("t3_vld",   32'(if_s1.first_vld), 32'd1);
        ack(1);

        // 10-input cone against exhaustive model evaluation
        gold_cnt = 0;
        gold_first = -1;
        for (int v = 0; v < 1024; v++) begin
            if (cone10(10'(v))) begin
                gold_cnt++;
                if (gold_first < 0) gold_first = v;
            end
        end
        sweep(2, 1'b0, 3000, edges);
        check("t4_latency", 32'(edges), 32'd1024);
        check("t4_cnt",   32'(if_n10.onset_cnt), 32'(gold_cnt));
        check("t4_first", 32'(if_n10.first_idx), 32'(gold_first));
        check("t4_vld",   32'(if_n10.first_vld), 32'd1);
        ack(2);

        // abort at vector 5
        mode = 2;
        if_s1.start = 1'b1;
        @(posedge clk);
        #1;
        if_s1.start = 1'b0;
        n = 0;
        while (if_s1.x != 4'd5 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_v5", 32'(n < 40), 32'd1);
        if_s1.abort = 1'b1;
        @(posedge clk);
        #1;
        if_s1.abort = 1'b0;
        check("abort_busy", 32'(if_s1.busy), 32'd0);
        check("abort_done", 32'(if_s1.done), 32'd0);
        check("abort_x",    32'(if_s1.x), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (if_s1.done || if_s1.busy) seen_done = 1'b1;
        end
        check("abort_stays_idle", 32'(seen_done), 32'd0);
        sweep(1, 1'b0, 200, edges);
        check("t5_latency", 32'(edges), 32'd32);
        check("t5_cnt",   32'(if_s1.onset_cnt), 32'd4);
        check("t5_first", 32'(if_s1.first_idx), 32'd9);
        ack(1);

        // asynchronous reset mid-sweep
        mode = 1;
        if_s1.start = 1'b1;
        @(posedge clk);
        #1;
        if_s1.start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_x",     32'(if_s1.x), 32'd0);
        check("mrst_busy",  32'(if_s1.busy), 32'd0);
        check("mrst_done",  32'(if_s1.done), 32'd0);
        check("mrst_cnt",   32'(if_s1.onset_cnt), 32'd0);
        check("mrst_first", 32'(if_s1.first_idx), 32'd0);
        check("mrst_vld",   32'(if_s1.first_vld), 32'd0);
`ifdef EXH_SWEEP_SIGNATURE_EN
        check("mrst_sig",   32'(if_s1.sig), 32'hFFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep(1, 1'b0, 200, edges);
        check("t6_latency", 32'(edges), 32'd32);
        check("t6_cnt",   32'(if_s1.onset_cnt), 32'd16);
        check("t6_first", 32'(if_s1.first_idx), 32'd0);
        check("t6_vld",   32'(if_s1.first_vld), 32'd1);
        ack(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
